adc_scan_ctrl: RTL and testbench

Sequences the dual-channel serial ADC front end (AD1-style, 16-bit frames: 4 leading zeros then 12 data bits MSB-first, both channels clocked together).
- Generates adc_cs and adc_clk and shifts in adc_d0 and adc_d1 in parallel.
- Schedules conversions at a fixed sample rate and reports overruns.
- Presents both channel results with valid and change strobes to the threshold/rpm chain.

---
 rtl/adc_scan_ctrl_pkg.sv | 28 ++
 rtl/adc_scan_ctrl_if.sv | 25 ++
 rtl/adc_sclk_gen.sv | 41 ++++
 rtl/adc_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_scan_ctrl_pkg.sv
// Shared constants, FSM state type and frame helpers for the dual-channel ADC scan controller.
// The serial frame is 4 leading zeros followed by 12 data bits, MSB first.
package adc_scan_ctrl_pkg;

  localparam int ADC_WIDTH      = 12;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_QUIET
  } scan_state_e;

  typedef logic [ADC_FRAME_BITS-1:0] adc_frame_t;
  typedef logic [ADC_WIDTH-1:0]      adc_value_t;

  // A frame is trustworthy only if the converter sent its leading zeros.
  function automatic logic lead_ok(input adc_frame_t f);
    return f[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS] == '0;
  endfunction

  function automatic adc_value_t frame_value(input adc_frame_t f);
    return f[ADC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Serial ADC pins plus the result bus presented to the threshold/rpm chain.
// master = scan controller, slave = converter/consumer side.
interface adc_scan_ctrl_if;
  import adc_scan_ctrl_pkg::*;

  logic       adc_cs;
  logic       adc_clk;
  logic       adc_d0;
  logic       adc_d1;
  adc_value_t value0;
  adc_value_t value1;
  logic       sample_valid;
  logic       change;

  modport master (
    output adc_cs, adc_clk, value0, value1, sample_valid, change,
    input  adc_d0, adc_d1
  );

  modport slave (
    input  adc_cs, adc_clk, value0, value1, sample_valid, change,
    output adc_d0, adc_d1
  );

endinterface

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: CLK_DIV mclk cycles per half-period, idles high while run_i=0.
// rise_o/fall_o flag that adc_clk toggles at the coming mclk edge (when running).
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic mclk,
  input  logic rst,
  input  logic run_i,
  output logic adc_clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q;
  logic          clk_q;
  logic          half_end;

  assign half_end = (div_q == CW'(CLK_DIV - 1));

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      clk_q <= 1'b1;
    end else if (!run_i) begin
      div_q <= '0;
      clk_q <= 1'b1;
    end else if (half_end) begin
      div_q <= '0;
      clk_q <= ~clk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign adc_clk_o = clk_q;
  assign rise_o    = half_end && !clk_q;
  assign fall_o    = half_end &&  clk_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Dual-channel serial ADC scan controller: fixed-rate scheduler with overrun tracking,
// frame sequencer (IDLE->SETUP->SHIFT->QUIET) and parallel shift-in of both channels.
module adc_scan_ctrl
  import adc_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 200,
  parameter int QUIET_CYC     = 4
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   enable,
  adc_scan_ctrl_if.master        adc,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  logic [PW-1:0] period_q;
  logic          tick;

  scan_state_e   state_q;
  logic          cs_q;
  logic          pending_q;
  logic [4:0]    bit_cnt_q;
  logic [QW-1:0] quiet_cnt_q;
  adc_frame_t    sh0_q;
  adc_frame_t    sh1_q;
  adc_value_t    value0_q;
  adc_value_t    value1_q;
  logic          valid_q;
  logic          change_q;
  logic          err_q;
  logic          ovr_q;
  logic          busy_q;

  logic          sclk;
  logic          sclk_rise;
  logic          sclk_fall;
  logic          sclk_run;
  logic          frame_done;

  // Scheduler: counter only runs while enabled, so the first tick lands on the
  // SAMPLE_PERIOD-th enabled cycle.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
    end else if (!enable || tick) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + 1'b1;
    end
  end

  assign tick = enable && (period_q == PW'(SAMPLE_PERIOD - 1));

  // The 16th sample is followed by one more high half-period; leaving SHIFT on that
  // half's falling strobe keeps adc_clk parked high instead of toggling low.
  assign frame_done = (state_q == ST_SHIFT) && (bit_cnt_q == 5'(ADC_FRAME_BITS)) && sclk_fall;
  assign sclk_run   = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && !frame_done);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .mclk      (mclk),
    .rst       (rst),
    .run_i     (sclk_run),
    .adc_clk_o (sclk),
    .rise_o    (sclk_rise),
    .fall_o    (sclk_fall)
  );

  // NOTE: every register here is updated with <=, so all branches see pre-edge values
  // and the later pending_q assignment in IDLE cleanly overrides the default.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b1;
      pending_q   <= 1'b0;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      value0_q    <= '0;
      value1_q    <= '0;
      valid_q     <= 1'b0;
      change_q    <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= tick && (state_q != ST_IDLE);

      if (!enable) begin
        pending_q <= 1'b0;
      end else if (tick && (state_q != ST_IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick || (pending_q && enable)) begin
            state_q   <= ST_SETUP;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
            bit_cnt_q <= '0;
          end
        end

        ST_SETUP: begin
          if (sclk_fall) begin
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (sclk_rise) begin
            sh0_q     <= {sh0_q[ADC_FRAME_BITS-2:0], adc.adc_d0};
            sh1_q     <= {sh1_q[ADC_FRAME_BITS-2:0], adc.adc_d1};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (frame_done) begin
            state_q     <= ST_QUIET;
            cs_q        <= 1'b1;
            quiet_cnt_q <= '0;
            if (lead_ok(sh0_q) && lead_ok(sh1_q)) begin
              value0_q <= frame_value(sh0_q);
              value1_q <= frame_value(sh1_q);
              valid_q  <= 1'b1;
              change_q <= (frame_value(sh0_q) != value0_q);
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_QUIET: begin
          if (quiet_cnt_q == QW'(QUIET_CYC - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            quiet_cnt_q <= quiet_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cs_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc.adc_cs       = cs_q;
  assign adc.adc_clk      = sclk;
  assign adc.value0       = value0_q;
  assign adc.value1       = value1_q;
  assign adc.sample_valid = valid_q;
  assign adc.change       = change_q;
  assign frame_err        = err_q;
  assign overrun          = ovr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench: a default-rate instance for frame timing/data/error/enable/reset cases
// and a SAMPLE_PERIOD=50 instance for overrun scheduling; outputs sampled on negedge mclk.
module tb_adc_scan_ctrl;
  import adc_scan_ctrl_pkg::*;

  localparam int CLK_DIV       = 2;
  localparam int SP_A          = 200;
  localparam int SP_B          = 50;
  localparam int QUIET_CYC     = 4;
  localparam int FRAME_CS_LOW  = 33 * CLK_DIV;      // 66
  localparam int TICK_TO_VALID = 1 + 33 * CLK_DIV;  // 67

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  logic enable_a = 1'b0;
  logic enable_b = 1'b0;
  logic frame_err_a, overrun_a, busy_a;
  logic frame_err_b, overrun_b, busy_b;

  adc_scan_ctrl_if bus_a ();
  adc_scan_ctrl_if bus_b ();

  adc_scan_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_A), .QUIET_CYC(QUIET_CYC)) dut_a (
    .mclk(mclk), .rst(rst), .enable(enable_a), .adc(bus_a),
    .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a)
  );

  adc_scan_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_B), .QUIET_CYC(QUIET_CYC)) dut_b (
    .mclk(mclk), .rst(rst), .enable(enable_b), .adc(bus_b),
    .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b)
  );

  always #5 mclk = ~mclk;

  int compared   = 0;
  int mismatched = 0;

  // ADC models: load the word while cs is high, present MSB, advance after each adc_clk rise.
  logic [15:0] w0_a, w1_a, w0_b, w1_b;
  logic [15:0] sr0_a = '0, sr1_a = '0, sr0_b = '0, sr1_b = '0;
  logic        clk_prev_a = 1'b1, clk_prev_b = 1'b1;

  always @(negedge mclk) begin
    if (bus_a.adc_cs) begin
      sr0_a = w0_a;
      sr1_a = w1_a;
    end else if (bus_a.adc_clk && !clk_prev_a) begin
      sr0_a = {sr0_a[14:0], 1'b0};
      sr1_a = {sr1_a[14:0], 1'b0};
    end
    clk_prev_a   = bus_a.adc_clk;
    bus_a.adc_d0 = sr0_a[15];
    bus_a.adc_d1 = sr1_a[15];
  end

  always @(negedge mclk) begin
    if (bus_b.adc_cs) begin
      sr0_b = w0_b;
      sr1_b = w1_b;
    end else if (bus_b.adc_clk && !clk_prev_b) begin
      sr0_b = {sr0_b[14:0], 1'b0};
      sr1_b = {sr1_b[14:0], 1'b0};
    end
    clk_prev_b   = bus_b.adc_clk;
    bus_b.adc_d0 = sr0_b[15];
    bus_b.adc_d1 = sr1_b[15];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step negedge by negedge until sample_valid or frame_err on instance A (bounded).
  task automatic run_a(input int limit, output int cyc, output int rises, output int lows,
                       output int gap, output int ovr, output logic got_valid, output logic got_err);
    logic prev_clk;
    logic in_gap;
    cyc = 0; rises = 0; lows = 0; ovr = 0; got_valid = 1'b0; got_err = 1'b0;
    in_gap   = bus_a.adc_cs;
    gap      = bus_a.adc_cs ? 1 : 0;
    prev_clk = bus_a.adc_clk;
    while (cyc < limit && !got_valid && !got_err) begin
      @(negedge mclk);
      cyc++;
      if (!bus_a.adc_cs) begin
        lows++;
        in_gap = 1'b0;
      end else if (in_gap) begin
        gap++;
      end
      if (bus_a.adc_clk && !prev_clk) rises++;
      prev_clk = bus_a.adc_clk;
      if (overrun_a) ovr++;
      got_valid = bus_a.sample_valid;
      got_err   = frame_err_a;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, rises, lows, gap, ovr;
    logic gv, ge;
    int   v_cyc[$];
    int   o_cyc[$];
    int   f_cyc[$];
    int   exp_v[4] = '{116, 187, 258, 329};
    int   exp_o[5] = '{100, 150, 200, 250, 300};
    int   exp_f[5] = '{50, 121, 192, 263, 334};
    logic prev_cs;
    int   n_valid, n_fall, n_ovr;

    w0_a = 16'h0ABC; w1_a = 16'h0123;
    w0_b = 16'h0555; w1_b = 16'h0AAA;

    // Reset state
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    check("rst_cs",     bus_a.adc_cs, 1);
    check("rst_sclk",   bus_a.adc_clk, 1);
    check("rst_busy",   busy_a, 0);
    check("rst_value0", bus_a.value0, 0);
    check("rst_value1", bus_a.value1, 0);
    check("rst_valid",  bus_a.sample_valid, 0);
    check("rst_err",    frame_err_a, 0);
    check("rst_ovr",    overrun_a, 0);

    // First frame: tick on the 200th enabled cycle (c199), valid 67 cycles later (c266)
    @(negedge mclk);
    enable_a = 1'b1;
    run_a(400, cyc, rises, lows, gap, ovr, gv, ge);
    check("f1_valid",   gv, 1);
    check("f1_latency", cyc, SP_A - 1 + TICK_TO_VALID);
    check("f1_value0",  bus_a.value0, 12'hABC);
    check("f1_value1",  bus_a.value1, 12'h123);
    check("f1_change",  bus_a.change, 1);
    check("f1_cs_low",  lows, FRAME_CS_LOW);
    check("f1_rises",   rises, 16);
    check("f1_ovr",     ovr, 0);

    // Identical second frame: one period later, no change, cs high for the rest of the period
    run_a(400, cyc, rises, lows, gap, ovr, gv, ge);
    check("f2_valid",  gv, 1);
    check("f2_period", cyc, SP_A);
    check("f2_change", bus_a.change, 0);
    check("f2_value0", bus_a.value0, 12'hABC);
    check("f2_cs_gap", gap, SP_A - FRAME_CS_LOW);
    check("f2_cs_low", lows, FRAME_CS_LOW);
    check("f2_rises",  rises, 16);

    // Channel 1 leading bits 0100: error, values held
    w1_a = 16'h4123;
    run_a(400, cyc, rises, lows, gap, ovr, gv, ge);
    check("err_seen",   ge, 1);
    check("err_period", cyc, SP_A);
    check("err_valid",  bus_a.sample_valid, 0);
    check("err_change", bus_a.change, 0);
    check("err_value0", bus_a.value0, 12'hABC);
    check("err_value1", bus_a.value1, 12'h123);
    @(negedge mclk);
    check("err_pulse_width", frame_err_a, 0);

    // Drop enable 16 cycles into SHIFT of the next frame (its tick is 133 cycles after the error pulse)
    w0_a = 16'h0456; w1_a = 16'h0789;
    repeat (149) @(negedge mclk);
    check("drop_pre_busy", busy_a, 1);
    check("drop_pre_cs",   bus_a.adc_cs, 0);
    enable_a = 1'b0;
    run_a(100, cyc, rises, lows, gap, ovr, gv, ge);
    check("drop_valid",   gv, 1);
    check("drop_latency", cyc, 50);
    check("drop_value0",  bus_a.value0, 12'h456);
    check("drop_value1",  bus_a.value1, 12'h789);
    check("drop_change",  bus_a.change, 1);
    run_a(300, cyc, rises, lows, gap, ovr, gv, ge);
    check("idle_no_valid", gv, 0);
    check("idle_cs_low",   lows, 0);
    check("idle_busy",     busy_a, 0);
    check("idle_cs",       bus_a.adc_cs, 1);

    // Asynchronous reset in the middle of SHIFT (c222: adc_clk low half)
    enable_a = 1'b1;
    repeat (222) @(negedge mclk);
    check("mid_pre_cs",   bus_a.adc_cs, 0);
    check("mid_pre_sclk", bus_a.adc_clk, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_cs",     bus_a.adc_cs, 1);
    check("mid_rst_sclk",   bus_a.adc_clk, 1);
    check("mid_rst_busy",   busy_a, 0);
    check("mid_rst_value0", bus_a.value0, 0);
    check("mid_rst_value1", bus_a.value1, 0);
    check("mid_rst_valid",  bus_a.sample_valid, 0);
    check("mid_rst_err",    frame_err_a, 0);
    check("mid_rst_ovr",    overrun_a, 0);
    enable_a = 1'b0;
    @(negedge mclk);
    rst = 1'b0;

    // SAMPLE_PERIOD=50: ticks at c49+50k, frames back-to-back (71 cycles incl. one IDLE cycle)
    @(negedge mclk);
    enable_b = 1'b1;
    prev_cs  = 1'b1;
    for (int k = 1; k <= 335; k++) begin
      @(negedge mclk);
      if (bus_b.sample_valid) v_cyc.push_back(k);
      if (overrun_b) o_cyc.push_back(k);
      if (prev_cs && !bus_b.adc_cs) f_cyc.push_back(k);
      prev_cs = bus_b.adc_cs;
    end
    check("ovr_n_valid", v_cyc.size(), 4);
    check("ovr_n_ovr",   o_cyc.size(), 5);
    check("ovr_n_start", f_cyc.size(), 5);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovr_valid_cyc%0d", i), (i < v_cyc.size()) ? v_cyc[i] : -1, exp_v[i]);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovr_pulse_cyc%0d", i), (i < o_cyc.size()) ? o_cyc[i] : -1, exp_o[i]);
    for (int i = 0; i < 5; i++)
      check($sformatf("ovr_start_cyc%0d", i), (i < f_cyc.size()) ? f_cyc[i] : -1, exp_f[i]);
    // Back-to-back gap: QUIET_CYC cycles of QUIET plus the one IDLE cycle
    check("ovr_cs_gap", (f_cyc.size() > 1 && v_cyc.size() > 0) ? f_cyc[1] - v_cyc[0] : -1, QUIET_CYC + 1);
    check("ovr_value0", bus_b.value0, 12'h555);
    check("ovr_value1", bus_b.value1, 12'hAAA);

    // Drop enable while frame 5 runs: it completes, pending is discarded, nothing more starts
    enable_b = 1'b0;
    n_valid = 0; n_fall = 0; n_ovr = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge mclk);
      if (bus_b.sample_valid) n_valid++;
      if (overrun_b) n_ovr++;
      if (prev_cs && !bus_b.adc_cs) n_fall++;
      prev_cs = bus_b.adc_cs;
    end
    check("ovr_stop_valid", n_valid, 1);
    check("ovr_stop_start", n_fall, 0);
    check("ovr_stop_ovr",   n_ovr, 0);
    check("ovr_stop_busy",  busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
